layer_acc_blk: RTL and testbench
================================

# layer_acc_blk

Multi-input-channel accumulation stage for the convolutional layer datapath. It takes per-pixel-group convolution results for all output channels, one input channel per beat, and sums them over `IN_FM_CH` beats with a per-output-channel bias. It then requantises each sum (round, shift, optional ReLU, saturate) and emits one result word per pixel group towards the output BRAM. It sits between the `conv_blk` array of the layer and the BRAM write port, generalising the layer from a single input channel to `IN_FM_CH` channels.

## Interface
- `NUM_PE`, default `` `NUM_PE ``: pixel lanes per output channel.
- `OUT_FM_CH`, default `` `OUT_FM_CH ``: output channels.
- `IN_FM_CH`, default `` `IN_FM_CH ``: beats accumulated per group; must be ≥1.
- `DW`, default `` `DW ``: input lane width, signed.
- `ACC_W`, default 32: accumulator and bias width; must be ≥ `DW` + clog2(`IN_FM_CH`) + 1.
- `OUT_W`, default 16: output lane width, signed.
- `SHIFT`, default 0: requantisation arithmetic right shift, 0..`ACC_W`-1.
- `RELU`, default 0: 1 clamps negative results to 0.
- `i_clk`  in  1  clock. One clock domain; all state changes on the rising edge.
- `i_rst`  in  1  reset. Synchronous, active-high.
- `i_bias_en`  in  1  load `i_bias_data` into the bias registers.
- `i_bias_data`  in  `ACC_W`*`OUT_FM_CH`  signed bias. Channel `oc` occupies bits `oc`*`ACC_W` +: `ACC_W`.
- `i_en`  in  1  `i_data` holds one valid input-channel beat.
- `i_data`  in  `DW`*`NUM_PE`*`OUT_FM_CH`  signed conv results. Lane k = `oc`*`NUM_PE`+`pe`, at bits k*`DW` +: `DW`.
- `o_en`  out  1  `o_result` valid; single-cycle pulse per group.
- `o_result`  out  `OUT_W`*`NUM_PE`*`OUT_FM_CH`  requantised results, same lane order as `i_data`.
- `o_busy`  out  1  a group is partially accumulated (beat counter ≠ 0).

## Operation
- Beat counter `cnt` runs 0..`IN_FM_CH`-1 and advances only on `i_en`. It wraps to 0 after the last beat.
- On `i_en` with `cnt`==0, each lane sets `acc` = bias[`oc`] + sext(`i_data` lane).
- On `i_en` with `cnt`>0, each lane sets `acc` = `acc` + sext(lane).
- Accumulator overflow wraps in two's complement. Sizing `ACC_W` correctly is the integrator's responsibility.
- `IN_FM_CH`==1: every beat is both first and last.
- On `i_en` with `cnt`==`IN_FM_CH`-1, the group is complete and `done` is set for exactly one cycle.
- While `done`=1, the output stage registers the requantised `acc` into `o_result` and pulses `o_en`.
- Requantisation per lane, in this order:
  - If `SHIFT`>0, add 2^(`SHIFT`-1) (round half up).
  - Arithmetic right shift by `SHIFT`.
  - If `RELU`=1, replace negatives with 0.
  - Saturate to [-2^(`OUT_W`-1), 2^(`OUT_W`-1)-1].
- The rounding add is computed at `ACC_W`+1 bits so it cannot overflow.
- `i_bias_en` may be asserted at any cycle; the new bias takes effect from the next first beat.
- If `i_bias_en` and a first beat coincide, the first beat uses the old bias.
- `i_en` low mid-group: the group stalls with `acc` and `cnt` held. There is no timeout.
- `o_result` holds its value between `o_en` pulses.
- `o_busy` is combinational from `cnt`.

## Timing
- Reset values: `cnt`=0, all `acc`=0, all bias=0, `done`=0, `o_en`=0, `o_result`=0, `o_busy`=0.
- Latency: a last beat sampled at edge N produces `o_en`=1 and valid `o_result` in the cycle after edge N+1, i.e. 2 cycles.
- Throughput: one beat per cycle, no bubbles.
- Back-to-back groups: the next group's first beat may arrive in the cycle after the previous group's last beat.
  - At that edge the output stage captures the old `acc` while `acc` reloads from bias.
  - The result must not be corrupted.
- Minimum spacing of `o_en` pulses is `IN_FM_CH` cycles.
- `i_rst` mid-group discards the partial group; no `o_en` is produced for it.
- `i_rst` while `done`=1 suppresses the pending `o_en`.
- `i_rst` has priority over `i_en` and `i_bias_en`.

## Structure
- Shared package `layer_pkg`, containing:
  - clog2 function;
  - the lane-index function (`oc`, `pe`) → k;
  - the defaults for `ACC_W` and `OUT_W`;
  - the `SHIFT` and `RELU` parameter checks.
- Sub-module `layer_requant`: purely combinational single-lane round/shift/ReLU/saturate, parametrised by `ACC_W`, `OUT_W`, `SHIFT`, `RELU`.
  - Instantiated `NUM_PE`*`OUT_FM_CH` times by generate.
  - The top level holds `cnt`, `acc`, bias, `done` and the output registers.

## Test plan
Common configuration: `NUM_PE`=2, `OUT_FM_CH`=2, `IN_FM_CH`=3, `DW`=16, `ACC_W`=32, `OUT_W`=16.
- Basic accumulation: bias {10,-5}, `SHIFT`=0, `RELU`=0; three consecutive beats, all lanes {100,200,-50} -> one `o_en` 2 cycles after the last beat; lanes of oc0 = 260, lanes of oc1 = 245.
- Saturation and ReLU: `RELU`=1, bias 0; beats all lanes {30000,30000,30000} -> 32767. Beats {-1000,-1,0} -> 0. Same with `RELU`=0 -> -1001.
- Rounding: `SHIFT`=2, bias 0; beats {5,0,0} -> 1, {6,0,0} -> 2, {-6,0,0} -> -1.
- Stalls and back-to-back: group A beats with 2-cycle `i_en` gaps, then group B starting the cycle after A's last beat -> A and B results both correct; `o_en` pulses exactly 3 cycles apart; `o_busy` high only mid-group.
- Bias timing: `i_bias_en` with new bias 7 in the same cycle as a group's first beat -> that group uses the old bias, the following group uses 7.
- Reset mid-operation: assert `i_rst` after 2 of 3 beats -> outputs return to reset values, no `o_en`; a fresh 3-beat group afterwards yields sum + bias 0.

Source files
------------

// File: rtl/layer_pkg.sv
// layer_pkg: shared definitions for the convolutional layer datapath.
//   - default geometry macros (overridable from the build)
//   - clog2 and lane-index helpers
//   - default accumulator / output widths
//   - parameter legality checks used at elaboration
`ifndef NUM_PE
`define NUM_PE 4
`endif
`ifndef OUT_FM_CH
`define OUT_FM_CH 4
`endif
`ifndef IN_FM_CH
`define IN_FM_CH 3
`endif
`ifndef DW
`define DW 16
`endif

package layer_pkg;

    localparam int unsigned ACC_W_DEF = 32;
    localparam int unsigned OUT_W_DEF = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    // Flat lane index for output channel oc, pixel lane pe.
    function automatic int unsigned lane_idx(input int unsigned oc,
                                             input int unsigned pe,
                                             input int unsigned num_pe);
        return oc * num_pe + pe;
    endfunction

    function automatic bit shift_ok(input int unsigned shift, input int unsigned acc_w);
        return shift < acc_w;
    endfunction

    function automatic bit relu_ok(input int unsigned relu);
        return relu <= 1;
    endfunction

endpackage

// File: rtl/layer_requant.sv
// layer_requant: combinational single-lane requantiser.
//   acc    : signed accumulator value (ACC_W bits)
//   result : round-half-up, arithmetic shift by SHIFT, optional ReLU,
//            saturated to signed OUT_W bits
module layer_requant
    import layer_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned RELU  = 0
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] result
);

    localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] ONE  = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] RND  = (SHIFT > 0) ? (ONE << RSH) : '0;
    localparam logic signed [ACC_W:0] MAXV = (ONE << (OUT_W-1)) - ONE;
    localparam logic signed [ACC_W:0] MINV = -(ONE << (OUT_W-1));

    // One extra bit so the rounding add cannot overflow.
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] sh;

    always_comb begin
        ext = {acc[ACC_W-1], acc};
        sum = ext + RND;
        sh  = sum >>> SHIFT;
        if (RELU == 1 && sh < 0) sh = '0;
        if (sh > MAXV)      result = MAXV[OUT_W-1:0];
        else if (sh < MINV) result = MINV[OUT_W-1:0];
        else                result = sh[OUT_W-1:0];
    end

endmodule

// File: rtl/layer_acc_blk.sv
// layer_acc_blk: accumulates IN_FM_CH input-channel beats per pixel group
// with a per-output-channel bias, then requantises and emits one result
// word per group.
//   i_clk / i_rst : clock, synchronous active-high reset
//   i_bias_en     : load i_bias_data (ACC_W per output channel)
//   i_en / i_data : one valid beat, DW-bit signed lanes, k = oc*NUM_PE+pe
//   o_en          : single-cycle pulse, o_result valid
//   o_result      : OUT_W-bit signed lanes, same order as i_data
//   o_busy        : group partially accumulated
module layer_acc_blk
    import layer_pkg::*;
#(
    parameter int unsigned NUM_PE    = `NUM_PE,
    parameter int unsigned OUT_FM_CH = `OUT_FM_CH,
    parameter int unsigned IN_FM_CH  = `IN_FM_CH,
    parameter int unsigned DW        = `DW,
    parameter int unsigned ACC_W     = ACC_W_DEF,
    parameter int unsigned OUT_W     = OUT_W_DEF,
    parameter int unsigned SHIFT     = 0,
    parameter int unsigned RELU      = 0
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_bias_en,
    input  logic [ACC_W*OUT_FM_CH-1:0]        i_bias_data,
    input  logic                              i_en,
    input  logic [DW*NUM_PE*OUT_FM_CH-1:0]    i_data,
    output logic                              o_en,
    output logic [OUT_W*NUM_PE*OUT_FM_CH-1:0] o_result,
    output logic                              o_busy
);

    localparam int unsigned NL = NUM_PE * OUT_FM_CH;
    localparam int unsigned CW = (clog2(IN_FM_CH) > 0) ? clog2(IN_FM_CH) : 1;
    localparam logic [CW-1:0] LAST = CW'(IN_FM_CH - 1);

    if (!shift_ok(SHIFT, ACC_W) || !relu_ok(RELU) || IN_FM_CH < 1
        || ACC_W < DW + clog2(IN_FM_CH) + 1 || OUT_W > ACC_W) begin : g_bad_param
        $error("layer_acc_blk: illegal parameter combination");
    end

    logic [CW-1:0]           cnt;
    logic                    done;
    logic signed [ACC_W-1:0] acc  [NL];
    logic signed [ACC_W-1:0] bias [OUT_FM_CH];
    logic signed [OUT_W-1:0] q    [NL];

    // Bias is read on the first beat before any same-cycle reload lands,
    // so a coincident i_bias_en only affects the following group.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt  <= '0;
            done <= 1'b0;
            for (int unsigned k = 0; k < NL; k++) acc[k] <= '0;
            for (int unsigned oc = 0; oc < OUT_FM_CH; oc++) bias[oc] <= '0;
        end else begin
            done <= i_en && (cnt == LAST);
            if (i_en) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
                for (int unsigned oc = 0; oc < OUT_FM_CH; oc++) begin
                    for (int unsigned pe = 0; pe < NUM_PE; pe++) begin
                        acc[lane_idx(oc, pe, NUM_PE)] <=
                            ((cnt == '0) ? bias[oc] : acc[lane_idx(oc, pe, NUM_PE)])
                            + ACC_W'(signed'(i_data[lane_idx(oc, pe, NUM_PE)*DW +: DW]));
                    end
                end
            end
            if (i_bias_en) begin
                for (int unsigned oc = 0; oc < OUT_FM_CH; oc++)
                    bias[oc] <= i_bias_data[oc*ACC_W +: ACC_W];
            end
        end
    end

    for (genvar k = 0; k < NL; k++) begin : g_lane
        layer_requant #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT),
            .RELU  (RELU)
        ) u_requant (
            .acc    (acc[k]),
            .result (q[k])
        );
    end

    // Captures acc while done is high; a back-to-back first beat reloads
    // acc on the same edge, so the old sum is what gets registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_en     <= 1'b0;
            o_result <= '0;
        end else begin
            o_en <= done;
            if (done) begin
                for (int unsigned k = 0; k < NL; k++)
                    o_result[k*OUT_W +: OUT_W] <= q[k];
            end
        end
    end

    assign o_busy = (cnt != '0);

endmodule

// File: tb/tb_layer_acc_blk.sv
// Bench for layer_acc_blk: three instances share stimulus (plain, ReLU,
// SHIFT=2); a reference model pushes expected results per group to a
// scoreboard popped whenever o_en fires.
module tb_layer_acc_blk;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_bias_en = 1'b0;
  logic [63:0] i_bias_data = '0;
  logic        i_en = 1'b0;
  logic [63:0] i_data = '0;

  logic        en_b, en_r, en_s;
  logic [63:0] res_b, res_r, res_s;
  logic        busy_b, busy_r, busy_s;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] r0;
    logic [63:0] r1;
    logic [63:0] r2;
    int          due;
  } exp_t;

  exp_t   expq[$];
  int     en_cyc[$];

  int     lv[4];
  int     nb[2];
  longint acc_m[4];
  longint bias_m[2];
  int     cnt_m = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_acc_blk #(.NUM_PE(2), .OUT_FM_CH(2), .IN_FM_CH(3), .DW(16),
                  .ACC_W(32), .OUT_W(16), .SHIFT(0), .RELU(0)) u_base (
    .i_clk(clk), .i_rst(i_rst), .i_bias_en(i_bias_en), .i_bias_data(i_bias_data),
    .i_en(i_en), .i_data(i_data), .o_en(en_b), .o_result(res_b), .o_busy(busy_b));

  layer_acc_blk #(.NUM_PE(2), .OUT_FM_CH(2), .IN_FM_CH(3), .DW(16),
                  .ACC_W(32), .OUT_W(16), .SHIFT(0), .RELU(1)) u_relu (
    .i_clk(clk), .i_rst(i_rst), .i_bias_en(i_bias_en), .i_bias_data(i_bias_data),
    .i_en(i_en), .i_data(i_data), .o_en(en_r), .o_result(res_r), .o_busy(busy_r));

  layer_acc_blk #(.NUM_PE(2), .OUT_FM_CH(2), .IN_FM_CH(3), .DW(16),
                  .ACC_W(32), .OUT_W(16), .SHIFT(2), .RELU(0)) u_rnd (
    .i_clk(clk), .i_rst(i_rst), .i_bias_en(i_bias_en), .i_bias_data(i_bias_data),
    .i_en(i_en), .i_data(i_data), .o_en(en_s), .o_result(res_s), .o_busy(busy_s));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] rq(input longint s, input int sh, input bit relu);
    longint v;
    logic [63:0] t;
    v = s;
    if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v = v >>> sh;
    if (relu && v < 0) v = 0;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    t = v;
    return t[15:0];
  endfunction

  function automatic logic [63:0] pack(input int sh, input bit relu);
    logic [63:0] r;
    for (int unsigned k = 0; k < 4; k++) r[k*16 +: 16] = rq(acc_m[k], sh, relu);
    return r;
  endfunction

  task automatic step(input bit en, input bit ben);
    exp_t e;
    logic [31:0] w;
    i_en = en;
    i_bias_en = ben;
    i_bias_data = {32'(nb[1]), 32'(nb[0])};
    for (int unsigned k = 0; k < 4; k++) begin
      w = lv[k];
      i_data[k*16 +: 16] = w[15:0];
    end
    if (en) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (cnt_m == 0) acc_m[k] = bias_m[k/2] + longint'(lv[k]);
        else            acc_m[k] = acc_m[k] + longint'(lv[k]);
      end
      if (cnt_m == 2) begin
        e.r0  = pack(0, 1'b0);
        e.r1  = pack(0, 1'b1);
        e.r2  = pack(2, 1'b0);
        e.due = cyc + 2;
        expq.push_back(e);
        cnt_m = 0;
      end else begin
        cnt_m++;
      end
    end
    if (ben) for (int unsigned oc = 0; oc < 2; oc++) bias_m[oc] = nb[oc];
    @(posedge clk);
    #1;
    i_en = 1'b0;
    i_bias_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    // A group completed on the previous edge is suppressed by this reset.
    while (expq.size() > 0 && expq[$].due > cyc) void'(expq.pop_back());
    i_rst = 1'b1;
    i_en = 1'b0;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    cnt_m = 0;
    for (int unsigned oc = 0; oc < 2; oc++) bias_m[oc] = 0;
    for (int unsigned k = 0; k < 4; k++) acc_m[k] = 0;
  endtask

  task automatic set_lanes(input int a, input int b, input int c, input int d);
    lv[0] = a; lv[1] = b; lv[2] = c; lv[3] = d;
  endtask

  task automatic group3(input int v0, input int v1, input int v2);
    set_lanes(v0, v0, v0, v0); step(1'b1, 1'b0);
    set_lanes(v1, v1, v1, v1); step(1'b1, 1'b0);
    set_lanes(v2, v2, v2, v2); step(1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (en_b || en_r || en_s) begin
      en_cyc.push_back(cyc);
      if (expq.size() == 0) begin
        chk("spurious_o_en", (en_b | en_r | en_s), 1'b0);
      end else begin
        e = expq.pop_front();
        chk("latency", cyc, e.due);
        chk("o_en_base", en_b, 1'b1);
        chk("o_en_relu", en_r, 1'b1);
        chk("o_en_rnd", en_s, 1'b1);
        chk("result_base", res_b, e.r0);
        chk("result_relu", res_r, e.r1);
        chk("result_rnd", res_s, e.r2);
      end
    end
  end

  initial begin
    for (int unsigned k = 0; k < 4; k++) begin acc_m[k] = 0; lv[k] = 0; end
    bias_m[0] = 0; bias_m[1] = 0; nb[0] = 0; nb[1] = 0;

    // Reset state
    idle(3);
    chk("rst_o_en", en_b, 1'b0);
    chk("rst_o_result", res_b, 64'h0);
    chk("rst_o_busy", busy_b, 1'b0);
    chk("rst_o_result_rnd", res_s, 64'h0);
    i_rst = 1'b0;
    idle(1);

    // Basic accumulation, bias {10,-5}
    nb[0] = 10; nb[1] = -5;
    step(1'b0, 1'b1);
    set_lanes(100, 100, 100, 100); step(1'b1, 1'b0);
    chk("busy_after_first", busy_b, 1'b1);
    set_lanes(200, 200, 200, 200); step(1'b1, 1'b0);
    set_lanes(-50, -50, -50, -50); step(1'b1, 1'b0);
    chk("busy_after_last", busy_b, 1'b0);
    idle(3);
    chk("basic_literal", res_b, {16'd245, 16'd245, 16'd260, 16'd260});

    // Saturation and ReLU, bias 0
    nb[0] = 0; nb[1] = 0;
    step(1'b0, 1'b1);
    group3(30000, 30000, 30000);
    idle(3);
    chk("sat_base", res_b, {4{16'h7fff}});
    chk("sat_relu", res_r, {4{16'h7fff}});
    group3(-1000, -1, 0);
    idle(3);
    chk("neg_base", res_b, {4{16'hfc17}});
    chk("neg_relu", res_r, 64'h0);

    // Rounding with SHIFT=2 on per-lane first beats
    set_lanes(5, 6, -6, 7); step(1'b1, 1'b0);
    set_lanes(0, 0, 0, 0);  step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(3);
    chk("round_literal", res_s, {16'd2, 16'hffff, 16'd2, 16'd1});

    // Group A with 2-cycle stalls, then group B back-to-back
    set_lanes(1, 2, 3, 4); step(1'b1, 1'b0);
    idle(2);
    chk("busy_stall", busy_b, 1'b1);
    set_lanes(10, 20, 30, 40); step(1'b1, 1'b0);
    idle(2);
    chk("busy_stall2", busy_b, 1'b1);
    set_lanes(100, 200, 300, 400); step(1'b1, 1'b0);
    chk("busy_between", busy_b, 1'b0);
    set_lanes(-7, 9, -300, 1234); step(1'b1, 1'b0);
    set_lanes(-8, 9, 500, -77);   step(1'b1, 1'b0);
    set_lanes(3, -2000, 1, 11);   step(1'b1, 1'b0);
    idle(4);
    chk("b2b_spacing", en_cyc[$] - en_cyc[$-1], 3);

    // Bias change coinciding with a first beat
    nb[0] = 7; nb[1] = 7;
    set_lanes(1, 1, 1, 1); step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(3);
    chk("bias_old", res_b, {4{16'd3}});
    group3(1, 1, 1);
    idle(3);
    chk("bias_new", res_b, {4{16'd10}});

    // Reset after 2 of 3 beats
    set_lanes(50, 50, 50, 50); step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    do_reset();
    chk("midrst_busy", busy_b, 1'b0);
    chk("midrst_result", res_b, 64'h0);
    chk("midrst_o_en", en_b, 1'b0);
    idle(4);
    group3(5, 5, 5);
    idle(3);
    chk("post_rst_group", res_b, {4{16'd15}});

    // Reset while done is pending
    group3(2, 2, 2);
    do_reset();
    idle(4);
    chk("done_rst_result", res_b, 64'h0);
    chk("done_rst_o_en", en_b, 1'b0);

    chk("pending_results", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
